// File: rtl/ipd_sample_io.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ipd_sample_io
// Description : Plant-side sequencer for the IPD controller. A free-running
//               tick counter paces the loop at SampleDiv clocks per sample.
//               For each sample it fetches y_k from the ADC (req/valid),
//               fires the controller's one-cycle enable, waits out the
//               controller pipeline, then saturates salida_IPD into an
//               unsigned DAC code and strobes dac_load.
// Optional    : IPD_SAMPLE_IO_TIMEOUT_EN enables the ADC answer timeout
//               (AdcTimeout cycles in REQ). Undefined: REQ waits forever
//               and adc_timeout is tied low.
// Ports       : clock, reset (async, active-low)
//               enable              loop run; low holds the tick counter
//               adc_req/adc_valid/adc_data   ADC handshake and sample
//               y_k, ipd_enable     registered sample and step strobe to IPD
//               salida_IPD          controller output (signed)
//               dac_data, dac_load  saturated DAC code and its load strobe
//               busy                sample in progress (REQ..OUT)
//               overrun             sticky: tick dropped while busy
//               adc_timeout         sticky: ADC did not answer in time
// Revision    : 1.0 - initial release
// ============================================================================
module ipd_sample_io #(
    parameter int Width       = 19,
    parameter int Presicion   = 0,
    parameter int OutWidth    = 12,
    parameter int SampleDiv   = 1000,
    parameter int PipeLatency = 4,
    parameter int AdcTimeout  = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    output logic                    adc_req,
    input  logic                    adc_valid,
    input  logic signed [Width-1:0] adc_data,
    output logic signed [Width-1:0] y_k,
    output logic                    ipd_enable,
    input  logic signed [Width-1:0] salida_IPD,
    output logic [OutWidth-1:0]     dac_data,
    output logic                    dac_load,
    output logic                    busy,
    output logic                    overrun,
    output logic                    adc_timeout
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_CNT_W  = (SampleDiv > 1) ? $clog2(SampleDiv) : 1;
    localparam int c_WAIT_W = (PipeLatency > 0) ? $clog2(PipeLatency + 1) : 1;

    localparam logic [c_CNT_W-1:0]  c_TICK_LAST = c_CNT_W'(SampleDiv - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(PipeLatency);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_STEP = 3'd2,
        S_WAIT = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  state_q;
    logic [c_CNT_W-1:0]      tick_cnt_q;
    logic [c_CNT_W-1:0]      tick_cnt_d;
    logic [c_WAIT_W-1:0]     wait_q;
    logic                    adc_req_q;
    logic signed [Width-1:0] y_k_q;
    logic                    ipd_enable_q;
    logic [OutWidth-1:0]     dac_data_q;
    logic                    dac_load_q;
    logic                    overrun_q;

    logic                    w_tick;
    logic signed [Width-1:0] w_shifted;
    logic [OutWidth-1:0]     w_sat;

`ifdef IPD_SAMPLE_IO_TIMEOUT_EN
    localparam int c_TO_W = (AdcTimeout > 1) ? $clog2(AdcTimeout) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(AdcTimeout - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    logic [c_TO_W-1:0] to_cnt_q;
    logic              timeout_q;
`else
    // Timeout depth has no meaning in this build; referenced only to keep
    // the parameter list identical across both configurations.
    logic w_unused_cfg;
    assign w_unused_cfg = (AdcTimeout < 0);
`endif

    // ------------------------------------------------------------------
    // Sample tick: the wrap of the 0..SampleDiv-1 counter. Holding enable
    // low parks the counter at 0, so the first tick after enable rises
    // lands exactly SampleDiv cycles later.
    // ------------------------------------------------------------------
    always_comb begin
        w_tick = enable && (tick_cnt_q == c_TICK_LAST);
        if (!enable || w_tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Saturation of the controller output into the unsigned DAC range.
    // After the arithmetic shift, a set sign bit means negative (clamp to
    // 0) and any set bit above the DAC width means too large (clamp to max).
    // ------------------------------------------------------------------
    always_comb begin
        w_shifted = salida_IPD >>> Presicion;
        if (w_shifted[Width-1]) begin
            w_sat = '0;
        end else if (|w_shifted[Width-2:OutWidth]) begin
            w_sat = '1;
        end else begin
            w_sat = w_shifted[OutWidth-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            wait_q       <= '0;
            adc_req_q    <= 1'b0;
            y_k_q        <= '0;
            ipd_enable_q <= 1'b0;
            dac_data_q   <= '0;
            dac_load_q   <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef IPD_SAMPLE_IO_TIMEOUT_EN
            to_cnt_q     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            tick_cnt_q <= tick_cnt_d;

            // A tick only exists while enable is high, so the clear and
            // the set can never compete.
            if (!enable) begin
                overrun_q <= 1'b0;
            end else if (w_tick && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end

`ifdef IPD_SAMPLE_IO_TIMEOUT_EN
            // Default clear; an abort in the same cycle overrides below.
            if (!enable) begin
                timeout_q <= 1'b0;
            end
`endif

            case (state_q)
                S_IDLE: begin
                    if (w_tick) begin
                        adc_req_q <= 1'b1;
                        state_q   <= S_REQ;
`ifdef IPD_SAMPLE_IO_TIMEOUT_EN
                        to_cnt_q  <= '0;
`endif
                    end
                end

                S_REQ: begin
                    if (adc_valid) begin
                        y_k_q        <= adc_data;
                        adc_req_q    <= 1'b0;
                        ipd_enable_q <= 1'b1;
                        state_q      <= S_STEP;
                    end
`ifdef IPD_SAMPLE_IO_TIMEOUT_EN
                    else if (to_cnt_q == c_TO_LAST) begin
                        // ADC silent for AdcTimeout cycles: abandon the
                        // sample, keep the previous y_k, no strobes.
                        adc_req_q <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + c_TO_ONE;
                    end
`endif
                end

                S_STEP: begin
                    ipd_enable_q <= 1'b0;
                    wait_q       <= c_WAIT_LOAD;
                    state_q      <= S_WAIT;
                end

                S_WAIT: begin
                    // PipeLatency WAIT cycles: the last one sees the valid
                    // controller output, captured here so dac_data and
                    // dac_load appear together in OUT.
                    if (wait_q <= c_WAIT_ONE) begin
                        dac_data_q <= w_sat;
                        dac_load_q <= 1'b1;
                        state_q    <= S_OUT;
                    end else begin
                        wait_q <= wait_q - c_WAIT_ONE;
                    end
                end

                S_OUT: begin
                    dac_load_q <= 1'b0;
                    state_q    <= S_IDLE;
                end

                default: begin
                    adc_req_q    <= 1'b0;
                    ipd_enable_q <= 1'b0;
                    dac_load_q   <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign adc_req    = adc_req_q;
    assign y_k        = y_k_q;
    assign ipd_enable = ipd_enable_q;
    assign dac_data   = dac_data_q;
    assign dac_load   = dac_load_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;

`ifdef IPD_SAMPLE_IO_TIMEOUT_EN
    assign adc_timeout = timeout_q;
`else
    assign adc_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ipd_sample_io.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ipd_sample_io
// Description : Self-checking bench for ipd_sample_io. Two instances share
//               the ADC handshake: one with Presicion=0 and one with
//               Presicion=4. Expected y_k and DAC codes are queued when the
//               stimulus is driven and popped when the DUT strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ipd_sample_io;

    localparam int c_W    = 19;
    localparam int c_OW   = 12;
    localparam int c_DIV  = 20;
    localparam int c_PIPE = 4;
    localparam int c_TO   = 10;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  enable;
    logic                  adc_valid;
    logic signed [c_W-1:0] adc_data;
    logic signed [c_W-1:0] salida_IPD;
    logic signed [c_W-1:0] salida_p4;

    logic                  adc_req,    adc_req_p4;
    logic signed [c_W-1:0] y_k,        y_k_p4;
    logic                  ipd_enable, ipd_enable_p4;
    logic [c_OW-1:0]       dac_data,   dac_data_p4;
    logic                  dac_load,   dac_load_p4;
    logic                  busy,       busy_p4;
    logic                  overrun,    overrun_p4;
    logic                  adc_timeout, adc_timeout_p4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_req_cyc = 0;
    logic signed [c_W-1:0] last_y = '0;

    logic signed [c_W-1:0] y_q[$];
    logic [c_OW-1:0]       dac_q[$];
    logic [c_OW-1:0]       dac4_q[$];

    ipd_sample_io #(
        .Width(c_W), .Presicion(0), .OutWidth(c_OW),
        .SampleDiv(c_DIV), .PipeLatency(c_PIPE), .AdcTimeout(c_TO)
    ) u_dut (
        .clock(clock), .reset(reset), .enable(enable),
        .adc_req(adc_req), .adc_valid(adc_valid), .adc_data(adc_data),
        .y_k(y_k), .ipd_enable(ipd_enable), .salida_IPD(salida_IPD),
        .dac_data(dac_data), .dac_load(dac_load), .busy(busy),
        .overrun(overrun), .adc_timeout(adc_timeout)
    );

    ipd_sample_io #(
        .Width(c_W), .Presicion(4), .OutWidth(c_OW),
        .SampleDiv(c_DIV), .PipeLatency(c_PIPE), .AdcTimeout(c_TO)
    ) u_dut_p4 (
        .clock(clock), .reset(reset), .enable(enable),
        .adc_req(adc_req_p4), .adc_valid(adc_valid), .adc_data(adc_data),
        .y_k(y_k_p4), .ipd_enable(ipd_enable_p4), .salida_IPD(salida_p4),
        .dac_data(dac_data_p4), .dac_load(dac_load_p4), .busy(busy_p4),
        .overrun(overrun_p4), .adc_timeout(adc_timeout_p4)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference saturation: shift, then clamp into 0..4095.
    function automatic logic [c_OW-1:0] sat_model(input logic signed [c_W-1:0] s, input int prec);
        int v;
        v = int'(s) >>> prec;
        if (v < 0) return '0;
        if (v > 4095) return 12'hFFF;
        return 12'(v);
    endfunction

    // One full sample: wait for adc_req, answer after 'delay' cycles, then
    // follow ipd_enable through to dac_load.
    task automatic run_sample(input int delay, input logic signed [c_W-1:0] yv,
                              input logic signed [c_W-1:0] sal, input logic signed [c_W-1:0] sal4,
                              input int exp_req, input bit drop_en, input bit glitch);
        bit seen;
        int e_cyc;
        int pulses;
        logic signed [c_W-1:0] exp_y;
        logic [c_OW-1:0] exp_d;
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clock);
            if (adc_req) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL req_wait: adc_req=%b, required 1 within 200 cycles", adc_req);
            return;
        end
        if (exp_req >= 0) begin
            checks++;
            if (cyc != exp_req) begin
                errors++;
                $display("FAIL req_time: adc_req rose at cycle %0d, required %0d", cyc, exp_req);
            end
        end
        last_req_cyc = cyc;
        if (drop_en) enable = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_req: busy=%b, required 1", busy);
        end
        repeat (delay) @(negedge clock);
        checks++;
        if (adc_req !== 1'b1) begin
            errors++;
            $display("FAIL req_hold: adc_req=%b before answer, required 1", adc_req);
        end
        adc_valid = 1'b1;
        adc_data  = yv;
        y_q.push_back(yv);
        @(negedge clock);
        adc_valid = 1'b0;
        adc_data  = 19'sh2AAAA;
        checks++;
        if (ipd_enable !== 1'b1 || adc_req !== 1'b0) begin
            errors++;
            $display("FAIL step: ipd_enable=%b adc_req=%b, required 1 0", ipd_enable, adc_req);
        end
        exp_y = y_q.pop_front();
        checks++;
        if (y_k !== exp_y) begin
            errors++;
            $display("FAIL yk: y_k=%0d, required %0d", y_k, exp_y);
        end
        last_y = exp_y;
        e_cyc  = cyc;
        salida_IPD = sal;
        salida_p4  = sal4;
        dac_q.push_back(sat_model(sal, 0));
        dac4_q.push_back(sat_model(sal4, 4));

        seen   = 0;
        pulses = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clock);
            adc_valid = 1'b0;
            if (ipd_enable) pulses++;
            if (dac_load) seen = 1;
            else if (glitch && k == 1) begin
                adc_valid = 1'b1;
                adc_data  = 19'sd777;
            end
        end
        exp_d = dac_q.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL dac_wait: dac_load never rose within 40 cycles, required 1");
            void'(dac4_q.pop_front());
            return;
        end
        checks++;
        if (cyc - e_cyc != c_PIPE + 1) begin
            errors++;
            $display("FAIL dac_lat: dac_load %0d cycles after ipd_enable, required %0d", cyc - e_cyc, c_PIPE + 1);
        end
        checks++;
        if (dac_data !== exp_d) begin
            errors++;
            $display("FAIL dac_data: got %0d, required %0d (salida %0d)", dac_data, exp_d, sal);
        end
        exp_d = dac4_q.pop_front();
        checks++;
        if (dac_load_p4 !== 1'b1 || dac_data_p4 !== exp_d) begin
            errors++;
            $display("FAIL dac_p4: load=%b data=%0d, required 1 %0d", dac_load_p4, dac_data_p4, exp_d);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL extra_step: %0d extra ipd_enable pulses, required 0", pulses);
        end
        checks++;
        if (y_k !== last_y) begin
            errors++;
            $display("FAIL yk_hold: y_k=%0d, required %0d", y_k, last_y);
        end
        @(negedge clock);
        checks++;
        if (dac_load !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL out_exit: dac_load=%b busy=%b, required 0 0", dac_load, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; adc_valid = 1'b0; adc_data = '0;
        salida_IPD = '0; salida_p4 = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (adc_req !== 1'b0 || ipd_enable !== 1'b0 || dac_load !== 1'b0) begin
            errors++;
            $display("FAIL rst_strobes: req=%b en=%b load=%b, required 0 0 0", adc_req, ipd_enable, dac_load);
        end
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0 || adc_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags: busy=%b ovr=%b to=%b, required 0 0 0", busy, overrun, adc_timeout);
        end
        checks++;
        if (y_k !== '0 || dac_data !== '0) begin
            errors++;
            $display("FAIL rst_data: y_k=%0d dac=%0d, required 0 0", y_k, dac_data);
        end
        checks++;
        if ({adc_req_p4, ipd_enable_p4, dac_load_p4, busy_p4, overrun_p4, adc_timeout_p4, y_k_p4, dac_data_p4} !== '0) begin
            errors++;
            $display("FAIL rst_p4: outputs of Presicion=4 instance not all 0");
        end
        reset = 1'b1;
        repeat (30) @(negedge clock);
        checks++;
        if (adc_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_disabled: adc_req=%b busy=%b with enable=0, required 0 0", adc_req, busy);
        end
    endtask

    task automatic test_periodic();
        int en_cyc;
        enable = 1'b1;
        en_cyc = cyc;
        run_sample(3, 19'sd123, -19'sd5, -19'sd5, en_cyc + c_DIV, 0, 0);
        run_sample(3, -19'sd77, 19'sd100, 19'sd100, last_req_cyc + c_DIV, 0, 0);
        run_sample(3, 19'sd4000, 19'sd4095, 19'sd4095, last_req_cyc + c_DIV, 0, 0);
    endtask

    task automatic test_saturation();
        run_sample(3, 19'sd11, 19'sd4096, 19'sd4096, last_req_cyc + c_DIV, 0, 0);
        run_sample(3, 19'sd12, 19'sh3FFFF, 19'sh3FFFF, last_req_cyc + c_DIV, 0, 0);
        run_sample(3, 19'sd13, 19'sd1600, 19'sd1600, last_req_cyc + c_DIV, 0, 0);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL no_overrun: overrun=%b at normal pacing, required 0", overrun);
        end
    endtask

    task automatic test_overrun();
        run_sample(30, 19'sd55, 19'sd200, 19'sd200, last_req_cyc + c_DIV, 0, 0);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: overrun=%b after slow ADC, required 1", overrun);
        end
        // The tick that arrived during the slow sample is dropped.
        run_sample(3, 19'sd56, 19'sd201, 19'sd201, last_req_cyc + 2 * c_DIV, 0, 0);
        enable = 1'b0;
        @(negedge clock);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clr: overrun=%b after enable=0, required 0", overrun);
        end
    endtask

    task automatic test_enable_drop();
        int en_cyc;
        int reqs;
        enable = 1'b1;
        en_cyc = cyc;
        run_sample(3, 19'sd300, 19'sd50, 19'sd50, en_cyc + c_DIV, 1, 0);
        reqs = 0;
        repeat (45) begin
            @(negedge clock);
            if (adc_req) reqs++;
        end
        checks++;
        if (reqs != 0) begin
            errors++;
            $display("FAIL no_tick: adc_req high %0d cycles with enable=0, required 0", reqs);
        end
    endtask

    task automatic test_ignore_valid();
        int en_cyc;
        adc_valid = 1'b1;
        adc_data  = 19'sd999;
        @(negedge clock);
        adc_valid = 1'b0;
        checks++;
        if (ipd_enable !== 1'b0 || busy !== 1'b0 || y_k !== last_y) begin
            errors++;
            $display("FAIL idle_valid: en=%b busy=%b y_k=%0d, required 0 0 %0d", ipd_enable, busy, y_k, last_y);
        end
        enable = 1'b1;
        en_cyc = cyc;
        run_sample(3, 19'sd400, 19'sd60, 19'sd60, en_cyc + c_DIV, 0, 1);
        enable = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_midsample();
        bit seen;
        int rel_cyc;
        enable = 1'b1;
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clock);
            if (adc_req) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_mid_req: adc_req=%b, required 1 within 100 cycles", adc_req);
        end
        repeat (3) @(negedge clock);
        adc_valid = 1'b1;
        adc_data  = 19'sd222;
        @(negedge clock);
        adc_valid = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (adc_req !== 1'b0 || ipd_enable !== 1'b0 || dac_load !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ctl: req=%b en=%b load=%b busy=%b, required 0", adc_req, ipd_enable, dac_load, busy);
        end
        checks++;
        if (dac_data !== '0 || y_k !== '0) begin
            errors++;
            $display("FAIL rst_mid_data: dac=%0d y_k=%0d, required 0 0", dac_data, y_k);
        end
        last_y = '0;
        @(negedge clock);
        reset   = 1'b1;
        rel_cyc = cyc;
        run_sample(3, 19'sd501, 19'sd1234, 19'sd1234, rel_cyc + c_DIV, 0, 0);
    endtask

    task automatic test_timeout();
`ifdef IPD_SAMPLE_IO_TIMEOUT_EN
        bit seen;
        int drop_at;
        int strobes;
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clock);
            if (adc_req) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL to_req: adc_req=%b, required 1 within 100 cycles", adc_req);
        end
        drop_at = -1;
        strobes = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (!adc_req && drop_at < 0) drop_at = k;
            if (ipd_enable || dac_load) strobes++;
        end
        checks++;
        if (drop_at != c_TO) begin
            errors++;
            $display("FAIL to_drop: adc_req dropped after %0d cycles, required %0d", drop_at, c_TO);
        end
        checks++;
        if (adc_timeout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_flag: adc_timeout=%b busy=%b, required 1 0", adc_timeout, busy);
        end
        checks++;
        if (strobes != 0 || y_k !== last_y) begin
            errors++;
            $display("FAIL to_quiet: strobes=%0d y_k=%0d, required 0 %0d", strobes, y_k, last_y);
        end
        enable = 1'b0;
        @(negedge clock);
        checks++;
        if (adc_timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_clr: adc_timeout=%b after enable=0, required 0", adc_timeout);
        end
`else
        run_sample(40, 19'sd600, 19'sd70, 19'sd70, last_req_cyc + c_DIV, 0, 0);
        checks++;
        if (adc_timeout !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout: adc_timeout=%b overrun=%b, required 0 1", adc_timeout, overrun);
        end
        enable = 1'b0;
        @(negedge clock);
`endif
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_saturation();
        test_overrun();
        test_enable_drop();
        test_ignore_valid();
        test_reset_midsample();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
